rgb_in_wait_fifo: RTL and testbench



---
 rtl/rgb_in_wait_fifo_pkg.sv | 35 +++
 rtl/rgb_in_wait_fifo_if.sv | 21 ++
 rtl/rgb_fifo_mem.sv | 24 ++
 rtl/rgb_in_wait_fifo.sv | 89 ++++++++
 tb/tb_rgb_in_wait_fifo.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/rgb_in_wait_fifo_pkg.sv
// rtl/rgb_in_wait_fifo_pkg.sv - shared pixel layout and sizing helpers for the input wait FIFO
package rgb_in_wait_fifo_pkg;

   localparam int PIX_W = 30;
   localparam int R_LSB = 20;
   localparam int G_LSB = 10;
   localparam int B_LSB = 0;
   localparam int CH_W  = 10;

   typedef enum logic [1:0] {
      OCC_IDLE = 2'b00,
      OCC_PUSH = 2'b10,
      OCC_POP  = 2'b01,
      OCC_BOTH = 2'b11
   } occ_op_e;

   function automatic int clog2_int(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic logic [PIX_W-1:0] pix_pack(input logic [CH_W-1:0] r,
                                                 input logic [CH_W-1:0] g,
                                                 input logic [CH_W-1:0] b);
      logic [PIX_W-1:0] p;
      p = '0;
      p[R_LSB +: CH_W] = r;
      p[G_LSB +: CH_W] = g;
      p[B_LSB +: CH_W] = b;
      return p;
   endfunction

endpackage

// File: rtl/rgb_in_wait_fifo_if.sv
// rtl/rgb_in_wait_fifo_if.sv - capture-side push and core-side show-ahead wait-port signals
interface rgb_in_wait_fifo_if #(
   parameter int width = 30
);
   logic             src_vld;
   logic [width-1:0] src_dat;
   logic             src_rdy;
   logic             lz;
   logic             vz;
   logic [width-1:0] z;

   modport slave (
      input  src_vld, src_dat, lz,
      output src_rdy, vz, z
   );

   modport master (
      output src_vld, src_dat, lz,
      input  src_rdy, vz, z
   );
endinterface

// File: rtl/rgb_fifo_mem.sv
// rtl/rgb_fifo_mem.sv - depth x width register array, synchronous write, asynchronous read
module rgb_fifo_mem #(
   parameter int width = 30,
   parameter int depth = 4,
   parameter int aw    = 2
) (
   input  logic             clk,
   input  logic             we,
   input  logic [aw-1:0]    waddr,
   input  logic [width-1:0] wdata,
   input  logic [aw-1:0]    raddr,
   output logic [width-1:0] rdata
);

   logic [width-1:0] mem_q [depth];

   // Storage is deliberately not reset; contents are only observed behind vz.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/rgb_in_wait_fifo.sv
// rtl/rgb_in_wait_fifo.sv - elastic RGB buffer feeding the tint core's wait-handshake input port
module rgb_in_wait_fifo
   import rgb_in_wait_fifo_pkg::*;
#(
   parameter int rscid   = 1,
   parameter int width   = PIX_W,
   parameter int fifo_sz = 4,
   parameter int ph_log2 = clog2_int(fifo_sz)
) (
   input  logic               clk,
   input  logic               arst,
   input  logic               en,
   rgb_in_wait_fifo_if.slave  port_if,
   output logic [ph_log2:0]   count,
   output logic               ovf,
   input  logic               ovf_clr
);

   localparam logic [ph_log2:0] FULL = (ph_log2+1)'(fifo_sz);

   if (fifo_sz < 2 || (fifo_sz & (fifo_sz - 1)) != 0 || (1 << ph_log2) != fifo_sz || rscid < 0)
   begin : g_bad_param
      $error("rgb_in_wait_fifo: fifo_sz must be a power of two >= 2 matching ph_log2");
   end

   logic [ph_log2-1:0] wr_ptr_q, wr_ptr_d;
   logic [ph_log2-1:0] rd_ptr_q, rd_ptr_d;
   logic [ph_log2:0]   count_q, count_d;
   logic               ovf_q, ovf_d;
   logic               push, pop, src_rdy, vz;
   occ_op_e            occ_op;

   // Ready and valid decode registered occupancy only, so lz never reaches src_rdy.
   assign src_rdy = (count_q != FULL);
   assign vz      = (count_q != '0);
   assign push    = en & port_if.src_vld & src_rdy;
   assign pop     = en & port_if.lz & vz;
   assign occ_op  = occ_op_e'({push, pop});

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + ph_log2'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ph_log2'(1);
      case (occ_op)
         OCC_PUSH: count_d = count_q + (ph_log2+1)'(1);
         OCC_POP:  count_d = count_q - (ph_log2+1)'(1);
         default:  count_d = count_q;
      endcase
      // A dropped word in the same cycle as a clear keeps the flag set.
      if (en & port_if.src_vld & ~src_rdy) ovf_d = 1'b1;
      else if (en & ovf_clr)               ovf_d = 1'b0;
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   rgb_fifo_mem #(
      .width (width),
      .depth (fifo_sz),
      .aw    (ph_log2)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (port_if.src_dat),
      .raddr (rd_ptr_q),
      .rdata (port_if.z)
   );

   assign port_if.src_rdy = src_rdy;
   assign port_if.vz      = vz;
   assign count           = count_q;
   assign ovf             = ovf_q;

endmodule

// File: tb/tb_rgb_in_wait_fifo.sv
// tb/tb_rgb_in_wait_fifo.sv - scoreboard bench for rgb_in_wait_fifo
module tb_rgb_in_wait_fifo;

   logic        clk = 1'b0;
   logic        arst;
   logic        en;
   logic        ovf_clr;
   logic [2:0]  count;
   logic        ovf;
   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [29:0] exp_q [$];

   rgb_in_wait_fifo_if #(.width(30)) bus ();

   rgb_in_wait_fifo #(
      .rscid   (1),
      .width   (30),
      .fifo_sz (4),
      .ph_log2 (2)
   ) dut (
      .clk     (clk),
      .arst    (arst),
      .en      (en),
      .port_if (bus),
      .count   (count),
      .ovf     (ovf),
      .ovf_clr (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [29:0] d);
      bus.src_vld = 1'b1;
      bus.src_dat = d;
      exp_q.push_back(d);
      tick();
      bus.src_vld = 1'b0;
   endtask

   task automatic drain(input int n);
      bus.lz = 1'b1;
      repeat (n) tick();
      bus.lz = 1'b0;
   endtask

   // Monitor: every enabled lz&vz cycle is a transfer of the scoreboard head.
   always @(negedge clk) begin
      if (!arst && en && bus.lz && bus.vz) begin
         if (exp_q.size() == 0) begin
            check("z_unexpected", {2'b0, bus.z}, 32'hFFFF_FFFF);
         end else begin
            check("z_order", {2'b0, bus.z}, {2'b0, exp_q[0]});
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      arst = 1'b1; en = 1'b1; ovf_clr = 1'b0;
      bus.src_vld = 1'b1; bus.src_dat = 30'h0; bus.lz = 1'b1;
      repeat (3) tick();
      check("rst_vz", {31'b0, bus.vz}, 32'd0);
      check("rst_count", {29'b0, count}, 32'd0);
      check("rst_src_rdy", {31'b0, bus.src_rdy}, 32'd1);
      check("rst_ovf", {31'b0, ovf}, 32'd0);
      bus.src_vld = 1'b0; bus.lz = 1'b0; arst = 1'b0;
      tick();

      push_word(30'h3FF00000);
      check("first_vz", {31'b0, bus.vz}, 32'd1);
      check("first_z", {2'b0, bus.z}, 32'h3FF00000);
      check("first_count", {29'b0, count}, 32'd1);
      drain(1);
      check("first_drained", {29'b0, count}, 32'd0);

      for (int i = 1; i <= 4; i++) push_word(30'(i));
      check("fill_count", {29'b0, count}, 32'd4);
      check("fill_src_rdy", {31'b0, bus.src_rdy}, 32'd0);
      drain(4);
      check("drain_vz", {31'b0, bus.vz}, 32'd0);
      check("drain_count", {29'b0, count}, 32'd0);

      push_word(30'h0A);
      push_word(30'h0B);
      bus.lz = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.src_vld = 1'b1;
         bus.src_dat = 30'h10 + 30'(i);
         exp_q.push_back(30'h10 + 30'(i));
         tick();
         check("steady_count", {29'b0, count}, 32'd2);
      end
      bus.src_vld = 1'b0;
      drain(2);
      check("steady_drained", {29'b0, count}, 32'd0);

      for (int i = 0; i < 4; i++) push_word(30'h21 + 30'(i));
      bus.src_vld = 1'b1; bus.src_dat = 30'hAAA;
      tick();
      check("ovf_set", {31'b0, ovf}, 32'd1);
      check("ovf_count", {29'b0, count}, 32'd4);
      bus.src_dat = 30'hBBB; ovf_clr = 1'b1;
      tick();
      check("ovf_set_wins", {31'b0, ovf}, 32'd1);
      bus.src_vld = 1'b0;
      tick();
      check("ovf_cleared", {31'b0, ovf}, 32'd0);
      ovf_clr = 1'b0;
      drain(4);
      check("ovf_drained", {29'b0, count}, 32'd0);

      for (int i = 0; i < 3; i++) push_word(30'h31 + 30'(i));
      en = 1'b0; bus.lz = 1'b1; bus.src_vld = 1'b1; bus.src_dat = 30'h3F;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_count", {29'b0, count}, 32'd3);
         check("hold_z", {2'b0, bus.z}, 32'h31);
         check("hold_ovf", {31'b0, ovf}, 32'd0);
      end
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.src_dat = 30'h41 + 30'(i);
         exp_q.push_back(30'h41 + 30'(i));
         tick();
         check("en_restore_count", {29'b0, count}, 32'd3);
      end
      bus.src_vld = 1'b0;
      drain(3);
      check("en_drained", {29'b0, count}, 32'd0);

      for (int i = 0; i < 3; i++) push_word(30'h51 + 30'(i));
      check("pre_rst_count", {29'b0, count}, 32'd3);
      #2 arst = 1'b1;
      exp_q.delete();
      #1;
      check("async_rst_vz", {31'b0, bus.vz}, 32'd0);
      check("async_rst_count", {29'b0, count}, 32'd0);
      check("async_rst_src_rdy", {31'b0, bus.src_rdy}, 32'd1);
      tick();
      arst = 1'b0;
      push_word(30'h155);
      check("post_rst_z", {2'b0, bus.z}, 32'h155);
      drain(1);
      check("post_rst_count", {29'b0, count}, 32'd0);

      repeat (2) tick();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
